// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the UART transmit arbiter.
// Imported by the arbiter top and its round-robin picker.
package uart_tx_arbiter_pkg;

    localparam int unsigned UartFrameBits = 10;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLaunch = 2'd1,
        StWait   = 2'd2
    } arb_state_e;

    // Zero baud yields zero so the caller's range check reports it instead of a divide fault.
    function automatic int unsigned cycles_per_bit(input int unsigned freq,
                                                   input int unsigned baud);
        return (baud == 0) ? 0 : freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: the first valid requester at or after ptr_i, wrapping.
// Produces a one-hot grant, its binary index and an any-valid flag.
module uart_tx_arbiter_rr_picker #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IdW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IdW-1:0]   ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IdW-1:0]   idx_o,
    output logic             any_valid_o
);

    int unsigned    cand;
    logic [IdW-1:0] cand_idx;

    always_comb begin
        grant_o     = '0;
        idx_o       = '0;
        any_valid_o = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = 32'(ptr_i) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IdW'(cand);
            if (!any_valid_o && valid_i[cand_idx]) begin
                any_valid_o       = 1'b1;
                idx_o             = cand_idx;
                grant_o[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_transmitter between N_REQ byte producers using round-robin arbitration.
// The transmitter has no busy flag, so a frame timer blocks the next launch until the frame ends.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NATIVE_CLK_FREQUENCY = 100000,
    parameter int unsigned BAUDRATE             = 9600,
    parameter int unsigned N_REQ                = 4,
    parameter int unsigned FRAME_BITS           = UartFrameBits,
    parameter int unsigned GUARD_CYCLES         = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     tx_sending,
    output logic [7:0]               tx_data,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id
);

    localparam int unsigned IdW         = $clog2(N_REQ);
    localparam int unsigned Cpb         = cycles_per_bit(NATIVE_CLK_FREQUENCY, BAUDRATE);
    localparam int unsigned FrameCycles = FRAME_BITS * Cpb + GUARD_CYCLES;
    localparam int unsigned CntW        = $clog2(FrameCycles + 1);

    if (Cpb < 1) begin : g_bad_cpb
        $error("uart_tx_arbiter: clock frequency / baud rate must be at least 1");
    end
    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
        $error("uart_tx_arbiter: N_REQ must lie in 2..16");
    end

    arb_state_e      state_q, state_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [IdW-1:0]  grant_id_q, grant_id_d;
    logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0] counter_q, counter_d;

    logic [N_REQ-1:0] pick_grant;
    logic [IdW-1:0]   pick_idx;
    logic             pick_any;

    uart_tx_arbiter_rr_picker #(
        .N_REQ(N_REQ)
    ) u_rr_picker (
        .valid_i    (req_valid),
        .ptr_i      (rr_ptr_q),
        .grant_o    (pick_grant),
        .idx_o      (pick_idx),
        .any_valid_o(pick_any)
    );

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        counter_d  = counter_q;
        req_ready  = '0;
        tx_sending = 1'b0;
        busy       = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Gated by rst_n so no accept is advertised while reset is held.
                if (pick_any && rst_n) begin
                    req_ready  = pick_grant;
                    tx_data_d  = req_data[{pick_idx, 3'b000} +: 8];
                    grant_id_d = pick_idx;
                    rr_ptr_d   = (32'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
                    state_d    = StLaunch;
                end
            end
            StLaunch: begin
                tx_sending = 1'b1;
                busy       = 1'b1;
                counter_d  = CntW'(FrameCycles - 1);
                state_d    = StWait;
            end
            StWait: begin
                busy = 1'b1;
                if (counter_q == '0) begin
                    state_d = StIdle;
                end else begin
                    counter_d = counter_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tx_data_q  <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            counter_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            counter_q  <= counter_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at default parameters (CPB=10, FRAME_CYCLES=100, N_REQ=4).
// Stimulus changes on the falling edge; outputs are sampled on the falling edge.
module tb_uart_tx_arbiter;

    localparam int Gap = 102;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        tx_sending;
    logic [7:0]  tx_data;
    logic        busy;
    logic [1:0]  grant_id;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_sending(tx_sending),
        .tx_data   (tx_data),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    task automatic wait_strobe(input int budget, output int at_cyc, output bit seen);
        seen   = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_sending === 1'b1) begin
                seen   = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        req_data  = 32'hDEADBEEF;
        rst_n     = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0000) begin
            miscompares++; $display("FAIL reset_ready: got %b required 0000", req_ready);
        end
        vectors++;
        if (tx_sending !== 1'b0) begin
            miscompares++; $display("FAIL reset_sending: got %b required 0", tx_sending);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy: got %b required 0", busy);
        end
        vectors++;
        if (tx_data !== 8'h00) begin
            miscompares++; $display("FAIL reset_data: got %h required 00", tx_data);
        end
        vectors++;
        if (grant_id !== 2'd0) begin
            miscompares++; $display("FAIL reset_grant: got %0d required 0", grant_id);
        end
        req_valid = '0;
        rst_n     = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int t;
        bit seen;
        int n;
        int extra;
        req_data[7:0] = 8'd15;
        req_valid     = 4'b0001;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++; $display("FAIL single_ready: got %b required 0001", req_ready);
        end
        wait_strobe(5, t, seen);
        req_valid = '0;
        vectors++;
        if (seen !== 1'b1) begin
            miscompares++; $display("FAIL single_strobe: seen=%b required 1", seen);
        end
        vectors++;
        if (tx_data !== 8'd15) begin
            miscompares++; $display("FAIL single_data: got %0d required 15", tx_data);
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL single_busy_launch: got %b required 1", busy);
        end
        n     = 0;
        extra = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_sending === 1'b1) extra++;
            if (busy !== 1'b1) break;
            n++;
        end
        vectors++;
        if (n !== 100) begin
            miscompares++; $display("FAIL single_busy_len: got %0d cycles after strobe required 100", n);
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++; $display("FAIL single_extra_strobe: got %0d required 0", extra);
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp_data [4];
        int t;
        int prev;
        bit seen;
        exp_data = '{8'd121, 8'd170, 8'd255, 8'd79};
        apply_reset();
        req_data  = {8'd79, 8'd255, 8'd170, 8'd121};
        req_valid = 4'hF;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++; $display("FAIL burst_ready: got %b required 0001", req_ready);
        end
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_strobe(120, t, seen);
            vectors++;
            if (seen !== 1'b1) begin
                miscompares++; $display("FAIL burst_strobe%0d: seen=%b required 1", k, seen);
            end
            vectors++;
            if (grant_id !== 2'(k)) begin
                miscompares++; $display("FAIL burst_grant%0d: got %0d required %0d", k, grant_id, k);
            end
            vectors++;
            if (tx_data !== exp_data[k]) begin
                miscompares++;
                $display("FAIL burst_data%0d: got %0d required %0d", k, tx_data, exp_data[k]);
            end
            if (k > 0) begin
                vectors++;
                if (t - prev !== Gap) begin
                    miscompares++;
                    $display("FAIL burst_gap%0d: got %0d required %0d", k, t - prev, Gap);
                end
            end
            prev         = t;
            req_valid[k] = 1'b0;
        end
        wait_idle(120);
    endtask

    task automatic test_fairness();
        logic [1:0] exp_id [4];
        int t;
        bit seen;
        exp_id         = '{2'd0, 2'd2, 2'd0, 2'd2};
        req_data[7:0]  = 8'd32;
        req_data[23:16] = 8'd79;
        req_valid      = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            wait_strobe(120, t, seen);
            vectors++;
            if (grant_id !== exp_id[k] || seen !== 1'b1) begin
                miscompares++;
                $display("FAIL fair_grant%0d: got %0d (seen=%b) required %0d",
                         k, grant_id, seen, exp_id[k]);
            end
            vectors++;
            if (tx_data !== ((exp_id[k] == 2'd0) ? 8'd32 : 8'd79)) begin
                miscompares++; $display("FAIL fair_data%0d: got %0d", k, tx_data);
            end
        end
        req_valid = '0;
        wait_idle(120);
    endtask

    task automatic test_ignore_busy();
        int t0;
        int t1;
        bit seen;
        int bad_data;
        int bad_strobe;
        req_data[15:8] = 8'hA5;
        req_valid      = 4'b0010;
        wait_strobe(10, t0, seen);
        vectors++;
        if (grant_id !== 2'd1 || tx_data !== 8'hA5 || seen !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore_first: grant=%0d data=%h seen=%b required 1/a5/1",
                     grant_id, tx_data, seen);
        end
        bad_data   = 0;
        bad_strobe = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_data !== 8'hA5) bad_data++;
            if (tx_sending !== 1'b0) bad_strobe++;
            if (i == 5) req_data[15:8] = 8'h3C;
            req_valid[1] = (i % 3) != 0;
        end
        req_valid[1] = 1'b1;
        vectors++;
        if (bad_data !== 0) begin
            miscompares++; $display("FAIL ignore_data_hold: %0d cycles changed, required 0", bad_data);
        end
        vectors++;
        if (bad_strobe !== 0) begin
            miscompares++; $display("FAIL ignore_no_strobe: %0d strobes, required 0", bad_strobe);
        end
        wait_strobe(100, t1, seen);
        vectors++;
        if (tx_data !== 8'h3C || seen !== 1'b1) begin
            miscompares++; $display("FAIL ignore_next_data: got %h (seen=%b) required 3c", tx_data, seen);
        end
        vectors++;
        if (t1 - t0 !== Gap) begin
            miscompares++; $display("FAIL ignore_gap: got %0d required %0d", t1 - t0, Gap);
        end
        req_valid = '0;
        wait_idle(120);
    endtask

    task automatic test_reset_mid_wait();
        int t;
        bit seen;
        req_data[23:16] = 8'h11;
        req_valid       = 4'b0100;
        wait_strobe(10, t, seen);
        req_valid = '0;
        vectors++;
        if (grant_id !== 2'd2 || seen !== 1'b1) begin
            miscompares++; $display("FAIL midrst_grant: got %0d (seen=%b) required 2", grant_id, seen);
        end
        repeat (40) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL midrst_busy_before: got %b required 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || tx_sending !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_async: busy=%b sending=%b required 0/0", busy, tx_sending);
        end
        req_data[31:8] = {8'h23, 8'h22, 8'h21};
        req_valid      = 4'b1110;
        #1;
        vectors++;
        if (req_ready !== 4'b0000) begin
            miscompares++; $display("FAIL midrst_ready: got %b required 0000", req_ready);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_strobe(5, t, seen);
        req_valid = '0;
        vectors++;
        if (grant_id !== 2'd1 || tx_data !== 8'h21 || seen !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_first_grant: grant=%0d data=%h seen=%b required 1/21/1",
                     grant_id, tx_data, seen);
        end
        wait_idle(120);
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_fairness();
        test_ignore_busy();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
